// File: rtl/intr_request_ctrl.sv
// intr_request_ctrl
// Initiator side of the intr/int_clr handshake towards the fetch-stage control.
// The external pin is synchronised, rising edges are counted in a saturating
// pending counter, and a request is raised only at a safe instruction boundary.
// Once raised, intr stays high until int_clr. The block then reports the
// in-service period until RTI retires.
//
// Optional build macro: INTR_NEST_EN
//   - Allows nested requests while a handler is in service, up to depth 3.
//   - Adds the nest_depth output.
//   - With the macro undefined there is no nesting and no nest_depth port.
module intr_request_ctrl #(
    parameter int SYNC_STAGES = 2,   // synchroniser depth, legal 2..4
    parameter int PEND_W      = 2    // pending counter width
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ext_int,
    input  logic              int_mask,
    input  logic              boundary,
    input  logic              stall_in,
    input  logic              int_clr,
    input  logic              rti_retire,
    output logic              intr,
    output logic              in_service,
    output logic [PEND_W-1:0] pending,
`ifdef INTR_NEST_EN
    output logic [1:0]        nest_depth,
`endif
    output logic              ovf
);

    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser and rising-edge detector
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   edge_pulse;

    // Shift the raw pin through the synchroniser; remember the last stage's
    // previous value so that a rise produces exactly one edge cycle.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = ext_int;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[SYNC_STAGES-1];
    end

    assign edge_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Synchroniser registers. Reset clears them, so no edge is seen at reset release.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              ovf_q, ovf_d;
    logic              intr_q, intr_d;
    logic              in_service_q, in_service_d;
    logic              request_ok;
    logic              accept;

    // A request needs queued work, no mask, a clean boundary and no stall.
    assign request_ok = (pending_q != '0) & ~int_mask & boundary & ~stall_in;

    // Acceptance is only meaningful while a request is outstanding.
    // An int_clr seen at any other time is ignored.
    assign accept = (state_q == ST_REQ) & int_clr;

`ifdef INTR_NEST_EN
    logic [1:0] depth_q, depth_d;

    // Next state with nesting. Each acceptance deepens the nesting level and
    // each RTI unwinds one level. A new request may interrupt a handler until
    // the depth reaches 3.
    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        case (state_q)
            ST_IDLE: begin
                if (request_ok) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (int_clr) begin
                    depth_d = depth_q + 2'd1;
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (rti_retire) begin
                    depth_d = depth_q - 2'd1;
                    if (depth_q == 2'd1) begin
                        state_d = ST_IDLE;
                    end
                end else if (request_ok && (depth_q != 2'd3)) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
                depth_d = 2'd0;
            end
        endcase
        intr_d       = (state_d == ST_REQ);
        in_service_d = (depth_d != 2'd0);
    end

    // Nesting depth register.
    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= 2'd0;
        end else begin
            depth_q <= depth_d;
        end
    end

    assign nest_depth = depth_q;
`else
    // Next state without nesting. Once a request is raised it can only end
    // through int_clr, so a request is never withdrawn.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (request_ok) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (int_clr) begin
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (rti_retire) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        intr_d       = (state_d == ST_REQ);
        in_service_d = (state_d == ST_SERVICE);
    end
`endif

    // Pending counter. An edge and an acceptance in the same cycle cancel.
    // An edge arriving while the counter is already full sets the sticky
    // overflow flag instead of counting.
    always_comb begin
        pending_d = pending_q;
        ovf_d     = ovf_q;
        case ({edge_pulse, accept})
            2'b10: begin
                if (pending_q == PEND_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    pending_d = pending_q + 1'b1;
                end
            end
            2'b01: begin
                if (pending_q != '0) begin
                    pending_d = pending_q - 1'b1;
                end
            end
            default: begin
                pending_d = pending_q;
            end
        endcase
    end

    // State, counter and registered outputs. Reset aborts any handshake and
    // discards all queued edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            ovf_q        <= 1'b0;
            intr_q       <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            ovf_q        <= ovf_d;
            intr_q       <= intr_d;
            in_service_q <= in_service_d;
        end
    end

    assign intr       = intr_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_intr_request_ctrl.sv
// Self-checking bench for intr_request_ctrl (default build, no nesting).
// Directed scenarios are followed by a randomised run. Every cycle is checked
// against a behavioural reference model.
module tb_intr_request_ctrl;

    localparam int S    = 2;
    localparam int PW   = 2;
    localparam int PMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          reset, ext_int, int_mask, boundary, stall_in, int_clr, rti_retire;
    logic          intr, in_service, ovf;
    logic [PW-1:0] pending;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int m_pend;
    bit m_ovf;
    bit m_req;
    bit m_svc;
    bit hist[S+1];   // hist[0] holds the most recent sampled pin value

    always #5 clk = ~clk;

    intr_request_ctrl #(.SYNC_STAGES(S), .PEND_W(PW)) dut (
        .clk        (clk),
        .reset      (reset),
        .ext_int    (ext_int),
        .int_mask   (int_mask),
        .boundary   (boundary),
        .stall_in   (stall_in),
        .int_clr    (int_clr),
        .rti_retire (rti_retire),
        .intr       (intr),
        .in_service (in_service),
        .pending    (pending),
        .ovf        (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Model of one clock edge. The rules are: an edge is counted S+1 clocks
    // after the pin is sampled high; the pending count saturates and sets
    // overflow when full; and a handshake runs idle -> requesting -> serving.
    task automatic model_update();
        bit edge_now, acc, ok;
        if (reset) begin
            m_pend = 0; m_ovf = 0; m_req = 0; m_svc = 0;
            for (int i = 0; i <= S; i++) hist[i] = 0;
        end else begin
            edge_now = hist[S-1] && !hist[S];
            for (int i = S; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = ext_int;
            acc = m_req && int_clr;
            ok  = (m_pend != 0) && !int_mask && boundary && !stall_in;
            if (edge_now && !acc) begin
                if (m_pend == PMAX) m_ovf = 1;
                else m_pend++;
            end else if (acc && !edge_now) begin
                m_pend--;
            end
            if (m_req) begin
                if (int_clr) begin m_req = 0; m_svc = 1; end
            end else if (m_svc) begin
                if (rti_retire) m_svc = 0;
            end else if (ok) begin
                m_req = 1;
            end
        end
    endtask

    // One clock: update the model at the edge, then compare shortly after it.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("intr", intr, m_req);
        chk("in_service", in_service, m_svc);
        chk("pending", pending, m_pend);
        chk("ovf", ovf, m_ovf);
    endtask

    task automatic pulse_edge();
        ext_int = 1'b1; step();
        ext_int = 1'b0; step();
    endtask

    task automatic wait_intr(input string tag);
        for (int i = 0; i < 20 && intr !== 1'b1; i++) step();
        chk(tag, intr, 1);
    endtask

    task automatic service_one();
        int_clr = 1'b1; step(); int_clr = 1'b0;
        rti_retire = 1'b1; step(); rti_retire = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ext_int = 0; int_mask = 0; boundary = 0;
        stall_in = 0; int_clr = 0; rti_retire = 0;
        for (int i = 0; i <= S; i++) hist[i] = 0;
        m_pend = 0; m_ovf = 0; m_req = 0; m_svc = 0;
        step(); step();
        reset = 1'b0; step();
        chk("rst_intr", intr, 0);
        chk("rst_in_service", in_service, 0);
        chk("rst_pending", pending, 0);
        chk("rst_ovf", ovf, 0);

        // Basic handshake and edge-to-pending latency
        boundary = 1'b1;
        pulse_edge(); step();
        chk("t1_pend_lat", pending, 1);
        chk("t1_intr_low", intr, 0);
        step();
        chk("t1_intr_high", intr, 1);
        int_clr = 1'b1; step(); int_clr = 1'b0;
        chk("t1_ack_intr", intr, 0);
        chk("t1_ack_svc", in_service, 1);
        chk("t1_ack_pend", pending, 0);
        rti_retire = 1'b1; step(); rti_retire = 1'b0;
        chk("t1_rti_svc", in_service, 0);

        // Masked edge is queued but not requested
        int_mask = 1'b1;
        pulse_edge(); repeat (4) step();
        chk("t2_pend", pending, 1);
        chk("t2_intr_masked", intr, 0);
        int_mask = 1'b0; step();
        chk("t2_intr_unmask", intr, 1);
        service_one();

        // No boundary, then stall, holds the request back
        boundary = 1'b0;
        pulse_edge(); step();
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin boundary = 1'b1; stall_in = 1'b1; end
            step();
            chk("t3_intr_held", intr, 0);
        end
        stall_in = 1'b0; step();
        chk("t3_intr_release", intr, 1);
        service_one();

        // Saturation and sticky overflow
        int_mask = 1'b1;
        repeat (5) pulse_edge();
        repeat (3) step();
        chk("t4_pend_sat", pending, 3);
        chk("t4_ovf", ovf, 1);
        int_mask = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_intr("t4_wait_intr");
            int_clr = 1'b1; step(); int_clr = 1'b0;
            chk("t4_pend_dec", pending, 2 - k);
            chk("t4_ovf_sticky", ovf, 1);
            rti_retire = 1'b1; step(); rti_retire = 1'b0;
        end

        // Edge coincident with acceptance leaves pending unchanged
        int_mask = 1'b1;
        pulse_edge(); repeat (3) step();
        chk("t5_pend", pending, 1);
        ext_int = 1'b1; step();
        ext_int = 1'b0; int_mask = 1'b0; step();
        chk("t5_intr", intr, 1);
        int_clr = 1'b1; step(); int_clr = 1'b0;
        chk("t5_pend_net0", pending, 1);
        chk("t5_svc", in_service, 1);
        rti_retire = 1'b1; step(); rti_retire = 1'b0;
        wait_intr("t5_second_intr");
        service_one();
        chk("t5_pend_end", pending, 0);

        // Reset while requesting with two queued edges
        int_mask = 1'b1;
        repeat (2) pulse_edge();
        repeat (3) step();
        chk("t6_pend", pending, 2);
        int_mask = 1'b0; step();
        chk("t6_intr", intr, 1);
        reset = 1'b1; step(); reset = 1'b0;
        chk("t6_rst_intr", intr, 0);
        chk("t6_rst_svc", in_service, 0);
        chk("t6_rst_pend", pending, 0);
        chk("t6_rst_ovf", ovf, 0);
        int_clr = 1'b1; step(); int_clr = 1'b0;
        chk("t6_clr_pend", pending, 0);
        chk("t6_clr_svc", in_service, 0);

        // Randomised run against the model
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(99) < 12) ext_int = ~ext_int;
            reset      = ($urandom_range(299) == 0);
            int_mask   = ($urandom_range(99) < 15);
            boundary   = ($urandom_range(99) < 70);
            stall_in   = ($urandom_range(99) < 20);
            int_clr    = ($urandom_range(99) < 25);
            rti_retire = ($urandom_range(99) < 25);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/intr_request_ctrl.md
Name: intr_request_ctrl

Overview:
- Interrupt-request controller. It is the initiator side of the intr/int_clr handshake consumed by the fetch-stage control unit.
- Synchronizes the external interrupt pin, detects rising edges and queues them in a saturating pending counter.
- Raises intr only at a safe instruction boundary, holds it until the fetch control acknowledges with int_clr, then tracks the in-service period until RTI retires.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on ext_int before edge detection (legal 2..4).
- PEND_W, 2, width of pending-edge counter; saturates at 2^PEND_W-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ext_int  in  1  asynchronous external interrupt pin, rising-edge significant
- int_mask  in  1  1 = suppress new requests (edges still queued)
- boundary  in  1  fetch control is at an instruction boundary (FETCH1, no 2nd byte/branch/wait pending)
- stall_in  in  1  pipeline stall; no request raised while high
- int_clr  in  1  acknowledge from fetch control (vector load taken)
- rti_retire  in  1  one-cycle pulse: RTI committed
- intr  out  1  interrupt request to fetch control
- in_service  out  1  handler executing
- pending  out  PEND_W  queued, unserviced edges
- ovf  out  1  sticky: edge arrived while pending saturated

Behaviour:
- One clock, synchronous active-high reset. All state updates on rising clk.
- Reset values: intr=0, in_service=0, pending=0, ovf=0, sync chain=0, FSM=IDLE. Reset mid-handshake aborts the request and drops all queued edges.
- Sync/edge: ext_int passes SYNC_STAGES flops. edge = last_stage & ~prev_stage, one cycle. Edge-to-pending latency = SYNC_STAGES+1 cycles.
- pending update, same cycle:
  - +1 on edge.
  - −1 on acceptance, defined as the cycle in REQ with int_clr=1.
  - Both in the same cycle: net 0.
  - Edge at max with no acceptance: hold at max, set ovf=1. ovf clears only on reset.
  - Never underflows.
- FSM:
  - IDLE: if pending!=0 & ~int_mask & boundary & ~stall_in, go to REQ. intr rises the cycle after the transition condition (registered output).
  - REQ: intr=1. On int_clr=1, go to SERVICE; intr=0 next cycle, in_service=1 next cycle. intr is held indefinitely until int_clr. int_mask and stall_in are ignored once in REQ, so a request is never withdrawn.
  - SERVICE: in_service=1, intr=0. On rti_retire=1, go to IDLE; in_service=0 next cycle. Edges continue to queue.
- rti_retire outside SERVICE is ignored. int_clr outside REQ is ignored with no effect on pending.
- Back-to-back: if pending is still nonzero after RTI, IDLE re-requests at the next qualifying boundary. Minimum gap from rti_retire to next intr rise is 2 cycles.
- A single int_clr pulse consumes exactly one pending edge.

Optional Feature:
- Macro INTR_NEST_EN.
- When defined:
  - In SERVICE, a qualifying condition (pending!=0 & ~int_mask & boundary & ~stall_in) raises intr again (SERVICE→REQ).
  - A 2-bit depth counter increments on each acceptance and decrements on rti_retire. Maximum depth 3; at depth 3 no further requests are raised.
  - in_service = (depth!=0). Return to IDLE when depth reaches 0.
  - Added output nest_depth[1:0].
- When undefined: no nesting, no nest_depth port, behaviour exactly as above.

Test Plan:
- Reset, then one ext_int pulse, boundary=1: pending=1 at cycle SYNC_STAGES+1; intr=1 one cycle later. int_clr one cycle after that: intr=0, in_service=1, pending=0. rti_retire: in_service=0.
- int_mask=1 during an edge: pending=1, intr stays 0. Drop the mask with boundary=1: intr=1 next cycle.
- boundary=0 or stall_in=1 held for 10 cycles with pending=1: intr=0 throughout. Release both: intr=1 next cycle.
- Five edges with no service, PEND_W=2: pending saturates at 3, ovf=1. Three full service cycles: pending 3→2→1→0, ovf stays 1.
- Edge coincident with int_clr acceptance while pending=1: pending stays 1. After RTI, a second intr is raised.
- Reset asserted while in REQ with pending=2: next cycle intr=0, in_service=0, pending=0, ovf=0. A later int_clr pulse has no effect.
